// File: rtl/debug_pkg.sv
// Shared definitions for the debug program loader: one-hot state encoding,
// default mode command bytes and word/byte helper constants.
package debug_pkg;

  localparam int NB_STATE = 9;
  typedef logic [NB_STATE-1:0] state_t;

  localparam state_t ST_IDLE      = 9'b0_0000_0001;
  localparam state_t ST_COUNT     = 9'b0_0000_0010;
  localparam state_t ST_LOAD      = 9'b0_0000_0100;
  localparam state_t ST_WRITE     = 9'b0_0000_1000;
  localparam state_t ST_WAIT_MODE = 9'b0_0001_0000;
  localparam state_t ST_STEP      = 9'b0_0010_0000;
  localparam state_t ST_RUN       = 9'b0_0100_0000;
  localparam state_t ST_DUMP      = 9'b0_1000_0000;
  localparam state_t ST_DONE      = 9'b1_0000_0000;

  localparam logic [7:0] MODE_STEP_DEF = 8'h0F;
  localparam logic [7:0] MODE_CONT_DEF = 8'hF0;

  localparam int NB_DATA_DEF    = 32;
  localparam int NB_BYTE_DEF    = 8;
  localparam int BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;
  localparam int NB_BYTECNT     = $clog2(BYTES_PER_WORD);

  // Counter width for n items that never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a byte stream into NB_DATA-bit words; the completed word is presented
// combinationally alongside the final byte so the writer can register it at once.
module byte_word_assembler
  import debug_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int NB_BYTE    = 8,
  parameter int BIG_ENDIAN = 0
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [NB_BYTE-1:0] data,
  input  logic               valid,
  output logic [NB_DATA-1:0] word,
  output logic               word_valid
);

  localparam int BPW   = NB_DATA / NB_BYTE;
  localparam int CNT_W = cnt_width(BPW);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

  logic [CNT_W-1:0]   cnt;
  logic [NB_DATA-1:0] shadow;
  int                 slot;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    word = shadow;
    slot = (BIG_ENDIAN != 0) ? (BPW - 1 - int'(cnt)) : int'(cnt);
    word[slot*NB_BYTE +: NB_BYTE] = data;
    word_valid = valid && (cnt == LAST);
  end

  // NOTE: shadow is datapath only and every slot is rewritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (valid) begin
      shadow <= word;
      cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debug_program_loader.sv
// Debug-unit core: loads a program from the UART byte stream into instruction
// memory, then gates the pipeline in step or continuous mode and requests dumps.
module debug_program_loader
  import debug_pkg::*;
#(
  parameter int                  NB_DATA       = 32,
  parameter int                  NB_BYTE       = 8,
  parameter int                  ADDRWIDTH     = 10,
  parameter int                  N_COUNT_BYTES = 1,
  parameter int                  BIG_ENDIAN    = 0,
  parameter logic [NB_BYTE-1:0]  MODE_STEP     = MODE_STEP_DEF,
  parameter logic [NB_BYTE-1:0]  MODE_CONT     = MODE_CONT_DEF
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [NB_BYTE-1:0]           rx_data_i,
  input  logic                         rx_valid_i,
  input  logic                         halt_i,
  input  logic                         dump_done_i,
  output logic                         mem_wr_en_o,
  output logic [ADDRWIDTH-1:0]         mem_addr_o,
  output logic [NB_DATA-1:0]           mem_data_o,
  output logic                         proc_enable_o,
  output logic                         ack_debug_o,
  output logic                         dump_req_o,
  output logic                         cmd_error_o,
  output logic                         done_o,
  output logic [8*N_COUNT_BYTES-1:0]   loaded_count_o
);

  localparam int NB_COUNT = 8 * N_COUNT_BYTES;
  localparam int HDR_W    = cnt_width(N_COUNT_BYTES);
  localparam logic [HDR_W-1:0] HDR_LAST = HDR_W'(N_COUNT_BYTES - 1);

  state_t               state;
  logic [HDR_W-1:0]     hdr_cnt;
  logic [NB_COUNT-1:0]  n_instr;
  logic [NB_COUNT-1:0]  n_next;
  logic [NB_COUNT-1:0]  count_next;
  logic [ADDRWIDTH-1:0] word_idx;
  logic                 last_word;
  logic                 asm_valid;
  logic                 word_valid;
  logic [NB_DATA-1:0]   word;

  // A byte arriving during a non-final WRITE is already byte 0 of the next word.
  always_comb begin
    n_next = n_instr;
    n_next[int'(hdr_cnt)*8 +: 8] = rx_data_i[7:0];
    count_next = loaded_count_o + 1'b1;
    last_word  = (count_next == n_instr);
    asm_valid  = rx_valid_i && ((state == ST_LOAD) || ((state == ST_WRITE) && !last_word));
  end

  byte_word_assembler #(
    .NB_DATA    (NB_DATA),
    .NB_BYTE    (NB_BYTE),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_assembler (
    .clk        (clock_i),
    .clear      (reset_i),
    .data       (rx_data_i),
    .valid      (asm_valid),
    .word       (word),
    .word_valid (word_valid)
  );

  // NOTE: all state and outputs update with non-blocking assignments so every output is a clean register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state          <= ST_IDLE;
      hdr_cnt        <= '0;
      n_instr        <= '0;
      word_idx       <= '0;
      mem_wr_en_o    <= 1'b0;
      mem_addr_o     <= '0;
      mem_data_o     <= '0;
      proc_enable_o  <= 1'b0;
      ack_debug_o    <= 1'b0;
      dump_req_o     <= 1'b0;
      cmd_error_o    <= 1'b0;
      done_o         <= 1'b0;
      loaded_count_o <= '0;
    end else begin
      mem_wr_en_o <= 1'b0;
      cmd_error_o <= 1'b0;
      case (state)
        ST_IDLE, ST_COUNT: begin
          if (rx_valid_i) begin
            n_instr <= n_next;
            if (hdr_cnt == HDR_LAST) begin
              hdr_cnt <= '0;
              if (n_next == '0) begin
                state       <= ST_WAIT_MODE;
                ack_debug_o <= 1'b1;
              end else begin
                state <= ST_LOAD;
              end
            end else begin
              hdr_cnt <= hdr_cnt + 1'b1;
              state   <= ST_COUNT;
            end
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            state       <= ST_WRITE;
            mem_wr_en_o <= 1'b1;
            mem_addr_o  <= word_idx;
            mem_data_o  <= word;
          end
        end
        ST_WRITE: begin
          loaded_count_o <= count_next;
          word_idx       <= word_idx + 1'b1;
          if (last_word) begin
            state       <= ST_WAIT_MODE;
            ack_debug_o <= 1'b1;
          end else if (word_valid) begin
            // Single-byte words can complete while still in WRITE.
            mem_wr_en_o <= 1'b1;
            mem_addr_o  <= word_idx + 1'b1;
            mem_data_o  <= word;
          end else begin
            state <= ST_LOAD;
          end
        end
        ST_WAIT_MODE: begin
          if (rx_valid_i) begin
            if (rx_data_i == MODE_STEP) begin
              state         <= ST_STEP;
              ack_debug_o   <= 1'b0;
              proc_enable_o <= 1'b1;
            end else if (rx_data_i == MODE_CONT) begin
              state         <= ST_RUN;
              ack_debug_o   <= 1'b0;
              proc_enable_o <= 1'b1;
            end else begin
              cmd_error_o <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          state         <= ST_DUMP;
          proc_enable_o <= 1'b0;
          dump_req_o    <= 1'b1;
        end
        ST_RUN: begin
          if (halt_i) begin
            state         <= ST_DUMP;
            proc_enable_o <= 1'b0;
            dump_req_o    <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (dump_done_i) begin
            dump_req_o <= 1'b0;
            if (halt_i) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
            end else begin
              state       <= ST_WAIT_MODE;
              ack_debug_o <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_o <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
